// File: rtl/mc_ctrl_pkg.sv
// Shared types and codes for the multi-cycle RV32I control sequencer.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned IMM_W   = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned OP_W    = 7;

  // Sequencer states
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // ALU operation codes
  typedef enum logic [ALUC_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } alu_ctrl_t;

  // Operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'd0,
    ALU_OP_SUB   = 2'd1,
    ALU_OP_RTYPE = 2'd2,
    ALU_OP_ITYPE = 2'd3
  } alu_op_t;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

  // Immediate formats
  localparam logic [IMM_W-1:0] IMM_I = 3'd0;
  localparam logic [IMM_W-1:0] IMM_S = 3'd1;
  localparam logic [IMM_W-1:0] IMM_B = 3'd2;
  localparam logic [IMM_W-1:0] IMM_J = 3'd3;
  localparam logic [IMM_W-1:0] IMM_U = 3'd4;

  // Mux selects
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'd0;
  localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'd1;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'd2;
  localparam logic [SEL_W-1:0] SRCA_PC       = 2'd0;
  localparam logic [SEL_W-1:0] SRCA_OLDPC    = 2'd1;
  localparam logic [SEL_W-1:0] SRCA_RD1      = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_RD2      = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_IMM      = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_FOUR     = 2'd2;

  // Immediate format implied by the opcode; unknown opcodes fall back to I
  function automatic logic [IMM_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// ALU decoder: funct3/funct7b5 and operation class to ALU operation code.
// Shared with the single-cycle control unit. sltu has no dedicated ALU code
// and is mapped onto SLT.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  alu_op_t    i_alu_op,
  output alu_ctrl_t  o_alu_control_c
);

  // Select ALU operation; only R-type honours SUB on funct3=000
  always_comb begin
    o_alu_control_c = ALU_ADD;
    case (i_alu_op)
      ALU_OP_ADD: o_alu_control_c = ALU_ADD;
      ALU_OP_SUB: o_alu_control_c = ALU_SUB;
      default: begin
        case (i_funct3)
          3'b000:  o_alu_control_c = ((i_alu_op == ALU_OP_RTYPE) && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control_c = ALU_SLL;
          3'b010:  o_alu_control_c = ALU_SLT;
          3'b011:  o_alu_control_c = ALU_SLT;
          3'b100:  o_alu_control_c = ALU_XOR;
          3'b101:  o_alu_control_c = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control_c = ALU_OR;
          default: o_alu_control_c = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer (Moore outputs, mem_ready/zero gated).
// Optional performance counters (instret, cycles) enabled by `PERF_CNT_EN.
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter bit          TRAP_HALT = 1'b1
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [SEL_W-1:0] ResultSrc,
  output logic [SEL_W-1:0] ALUSrcA,
  output logic [SEL_W-1:0] ALUSrcB,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [IMM_W-1:0] ImmSrc,
  output logic             RegWrite,
  output logic             illegal,
  output logic [STATE_W-1:0] state_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
`endif
);

  state_t    r_state;
  state_t    w_next;
  alu_op_t   w_alu_op;
  alu_ctrl_t w_alu_ctrl;

  // Reject a zero-width counter configuration at elaboration
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  alu_decoder u_alu_decoder (
    .i_funct3        (funct3),
    .i_funct7b5      (funct7b5),
    .i_alu_op        (w_alu_op),
    .o_alu_control_c (w_alu_ctrl)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and control outputs; everything is forced idle while reset is low
  always_comb begin
    w_next     = r_state;
    w_alu_op   = ALU_OP_ADD;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    ImmSrc     = imm_src_of(opcode);
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        w_next  = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEMDATA;
        RegWrite  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_RD2;
        w_alu_op = ALU_OP_RTYPE;
        w_next   = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        w_alu_op = ALU_OP_ITYPE;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_RD2;
        w_alu_op = ALU_OP_SUB;
        // Only beq/bne are supported; other branch kinds trap without redirecting
        if (funct3[2:1] == 2'b00) begin
          PCWrite = zero ^ funct3[0];
          w_next  = S_FETCH;
        end else begin
          w_next  = S_TRAP;
        end
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        w_next  = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        w_next  = TRAP_HALT ? S_TRAP : S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    if (!reset) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      illegal   = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      ImmSrc    = IMM_I;
    end
  end

  assign ALUControl = reset ? w_alu_ctrl : ALU_ADD;
  assign state_o    = r_state;

`ifdef PERF_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_cycles;

  // An instruction retires when a non-trap state hands control back to FETCH
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP);

  // Free-running cycle and retired-instruction counters, wrapping naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles  <= '0;
      r_instret <= '0;
    end else begin
      r_cycles <= r_cycles + CNT_W'(1);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = r_instret;
  assign cycles  = r_cycles;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized self-checking bench for multicycle_ctrl_fsm.
// Expected per-cycle controls come from per-instruction phase lists.
module tb_multicycle_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic [3:0] state_o;
`ifdef PERF_CNT_EN
  logic [31:0] instret, cycles;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(32), .TRAP_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .illegal(illegal), .state_o(state_o)
`ifdef PERF_CNT_EN
    , .instret(instret), .cycles(cycles)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [22:0] exp_v = '0;
  bit          exp_valid = 1'b0;
  logic [22:0] act_v;
  assign act_v = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, RegWrite, illegal, state_o};

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b1101111:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd6;
      3'd2:    return 4'd5;
      3'd3:    return 4'd5;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd8 : 4'd7;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Control word a given phase of an instruction must present
  function automatic logic [22:0] exp_vec(input state_t ph, input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7, input logic mr, input logic z);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b;
    logic [3:0] alu;
    {pcw, adr, mw, irw, rw, ill} = '0;
    rs = 2'd0; a = 2'd0; b = 2'd0; alu = 4'd0;
    case (ph)
      S_FETCH:    begin b = 2'd2; rs = 2'd2; irw = mr; pcw = mr; end
      S_DECODE:   begin a = 2'd1; b = 2'd1; end
      S_MEMADR:   begin a = 2'd2; b = 2'd1; end
      S_MEMREAD:  adr = 1'b1;
      S_MEMWB:    begin rs = 2'd1; rw = 1'b1; end
      S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      S_EXECR:    begin a = 2'd2; alu = ref_alu(f3, f7, 1'b1); end
      S_EXECI:    begin a = 2'd2; b = 2'd1; alu = ref_alu(f3, f7, 1'b0); end
      S_ALUWB:    rw = 1'b1;
      S_BRANCH:   begin a = 2'd2; alu = 4'd1; pcw = z ^ f3[0]; end
      S_JAL:      begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
      S_TRAP:     ill = 1'b1;
      default:    ;
    endcase
    return {pcw, adr, mw, irw, rs, a, b, alu, ref_imm(op), rw, ill, 4'(ph)};
  endfunction

  // Sequence of phases an instruction walks through (stall repeats excluded)
  function automatic int build_phases(input logic [6:0] op, output state_t ph[6]);
    for (int i = 0; i < 6; i++) ph[i] = S_FETCH;
    ph[1] = S_DECODE;
    case (op)
      7'b0110011: begin ph[2] = S_EXECR;  ph[3] = S_ALUWB; return 4; end
      7'b0010011: begin ph[2] = S_EXECI;  ph[3] = S_ALUWB; return 4; end
      7'b0000011: begin ph[2] = S_MEMADR; ph[3] = S_MEMREAD; ph[4] = S_MEMWB; return 5; end
      7'b0100011: begin ph[2] = S_MEMADR; ph[3] = S_MEMWRITE; return 4; end
      7'b1100011: begin ph[2] = S_BRANCH; return 3; end
      7'b1101111: begin ph[2] = S_JAL;    ph[3] = S_ALUWB; return 4; end
      default:    begin ph[2] = S_TRAP;   return 3; end
    endcase
  endfunction

  task automatic check_lit(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Hold reset low for one cycle (called at posedge+2), then release
  task automatic apply_reset();
    reset = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    exp_v = '0;
    exp_valid = 1'b1;
    #1;
    check_lit("reset_state", int'(state_o), int'(S_FETCH));
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  // Drive one instruction to completion (entered and left at posedge+2)
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input bit rand_mr, input int rd_stalls, input int zero_force,
                           input bit abort_mw, output int ncyc, output int nrw,
                           output logic [1:0] rs_rw, output logic pcw_br, output logic [3:0] alu_ex);
    state_t ph[6];
    int n, idx, stalls_left, bad, ill;
    logic mr, z;
    n = build_phases(op, ph);
    opcode = op; funct3 = f3; funct7b5 = f7;
    idx = 0; ncyc = 0; nrw = 0; rs_rw = '0; pcw_br = 1'b0; alu_ex = '0;
    stalls_left = rd_stalls;
    while (idx < n) begin
      mr = rand_mr ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ph[idx] == S_MEMREAD && stalls_left > 0) begin mr = 1'b0; stalls_left--; end
      if (abort_mw && ph[idx] == S_MEMWRITE) mr = 1'b0;
      z = (zero_force < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_force);
      mem_ready = mr; zero = z;
      exp_v = exp_vec(ph[idx], op, f3, f7, mr, z);
      exp_valid = 1'b1;
      #1;
      if (RegWrite) begin nrw++; rs_rw = ResultSrc; end
      if (ph[idx] == S_BRANCH) pcw_br = PCWrite;
      if (ph[idx] == S_EXECR || ph[idx] == S_EXECI) alu_ex = ALUControl;
      ncyc++;
      if (abort_mw && ph[idx] == S_MEMWRITE) begin
        @(negedge clk); #2;
        exp_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_lit("abort_memwrite_drop", int'(MemWrite), 0);
        check_lit("abort_state_fetch", int'(state_o), int'(S_FETCH));
        @(posedge clk); #2;
        apply_reset();
        return;
      end
      @(posedge clk); #2;
      if (!((ph[idx] == S_FETCH || ph[idx] == S_MEMREAD || ph[idx] == S_MEMWRITE) && !mr)) idx++;
    end
    if (ph[n-1] == S_TRAP) begin
      bad = 0; ill = 0;
      for (int k = 0; k < 5; k++) begin
        mem_ready = 1'($urandom_range(0, 1));
        exp_v = exp_vec(S_TRAP, op, f3, f7, 1'b0, 1'b0);
        #1;
        if (PCWrite || IRWrite || MemWrite || RegWrite) bad++;
        if (illegal) ill++;
        @(posedge clk); #2;
      end
      check_lit("trap_no_enables", bad, 0);
      check_lit("trap_illegal_held", ill, 5);
      apply_reset();
    end
  endtask

  initial begin
    fork
      // Per-cycle compare against the model
      begin
        forever begin
          @(negedge clk);
          if (exp_valid) begin
            n_vec++;
            if (act_v !== exp_v) begin
              n_err++;
              $display("FAIL ctrl_word t=%0t state=%0d actual=%h required=%h",
                       $time, state_o, act_v, exp_v);
            end
          end
        end
      end
      // Stimulus
      begin
        int ncyc, nrw, r;
        logic [1:0] rs_rw;
        logic pcw_br;
        logic [3:0] alu_ex;
        logic [6:0] op;
        logic [6:0] bad_ops[4];
        bad_ops[0] = 7'b1111111; bad_ops[1] = 7'b0110111;
        bad_ops[2] = 7'b0000000; bad_ops[3] = 7'b1100111;

        apply_reset();

`ifdef PERF_CNT_EN
        for (int i = 0; i < 10; i++)
          run_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 0, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("perf_instret", int'(instret), 10);
        check_lit("perf_cycles", int'(cycles), 40);
`endif

        run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("add_cycles", ncyc, 4);
        check_lit("add_regwrite_count", nrw, 1);
        check_lit("add_aluctrl", int'(alu_ex), 0);

        run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("sub_aluctrl", int'(alu_ex), 1);

        run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("addi_no_subi", int'(alu_ex), 0);

        run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("lw_stall_cycles", ncyc, 8);
        check_lit("lw_regwrite_count", nrw, 1);
        check_lit("lw_resultsrc", int'(rs_rw), 1);

        run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 0, 1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("beq_taken_pcwrite", int'(pcw_br), 1);
        check_lit("beq_cycles", ncyc, 3);

        run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("bne_not_taken_pcwrite", int'(pcw_br), 0);
        check_lit("bne_cycles", ncyc, 3);

        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("sw_cycles", ncyc, 4);
        check_lit("sw_regwrite_count", nrw, 0);

        run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        check_lit("jal_cycles", ncyc, 4);

        run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);

        run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, -1, 1'b1, ncyc, nrw, rs_rw, pcw_br, alu_ex);

        for (int i = 0; i < 300; i++) begin
          r = int'($urandom_range(0, 99));
          if (r < 25)      op = 7'b0110011;
          else if (r < 50) op = 7'b0010011;
          else if (r < 62) op = 7'b0000011;
          else if (r < 72) op = 7'b0100011;
          else if (r < 84) op = 7'b1100011;
          else if (r < 92) op = 7'b1101111;
          else             op = bad_ops[$urandom_range(0, 3)];
          run_instr(op, (op == 7'b1100011) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'b1, 0, -1, 1'b0, ncyc, nrw, rs_rw, pcw_br, alu_ex);
        end

        exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    join_any
  end

endmodule
